// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM APB arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DRAIN
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port not served last.
module sdram_arb_rr
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    case (req)
      2'b10:   gnt = PORT1;
      2'b11:   gnt = ~last;
      default: gnt = PORT0;
    endcase
  end

endmodule

// File: rtl/sdram_apb_arbiter.sv
// Two-requester APB arbiter in front of the SDRAM controller APB port: round-robin grant,
// one transfer in flight, per-transfer watchdog and a drain state that swallows late completions.
module sdram_apb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in0_psel,
  input  logic                in0_penable,
  input  logic                in0_pwrite,
  input  logic [ADDR_W-1:0]   in0_paddr,
  input  logic [2:0]          in0_pprot,
  input  logic [DATA_W-1:0]   in0_pwdata,
  input  logic [DATA_W/8-1:0] in0_pstrb,
  output logic                in0_pready,
  output logic [DATA_W-1:0]   in0_prdata,
  output logic                in0_pslverr,
  input  logic                in1_psel,
  input  logic                in1_penable,
  input  logic                in1_pwrite,
  input  logic [ADDR_W-1:0]   in1_paddr,
  input  logic [2:0]          in1_pprot,
  input  logic [DATA_W-1:0]   in1_pwdata,
  input  logic [DATA_W/8-1:0] in1_pstrb,
  output logic                in1_pready,
  output logic [DATA_W-1:0]   in1_prdata,
  output logic                in1_pslverr,
  output logic                out_psel,
  output logic                out_penable,
  output logic                out_pwrite,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic [2:0]          out_pprot,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr
);

  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 1) ? WDOG_W'(TIMEOUT - 1) : '0;

  state_t            state;
  logic              gnt, last, psel_q, penable_q;
  logic              pick_gnt, pick_vld, done, expire, live0, live1;
  logic [WDOG_W-1:0] wdog;

  sdram_arb_rr u_rr (
    .req   ({in1_psel, in0_psel}),
    .last  (last),
    .gnt   (pick_gnt),
    .valid (pick_vld)
  );

  assign done   = (state == ST_ACCESS) && out_pready;
  assign expire = (state == ST_ACCESS) && !out_pready && (TIMEOUT != 0) && (wdog == WDOG_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      gnt       <= PORT0;
      last      <= PORT1;
      wdog      <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt    <= pick_gnt;
            psel_q <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          wdog      <= '0;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A real completion takes priority over a watchdog expiry in the same cycle.
          if (done || expire) begin
            last      <= gnt;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= done ? ST_IDLE : ST_DRAIN;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        ST_DRAIN: begin
          if (out_pready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_psel    = psel_q;
  assign out_penable = penable_q;

  // Request fields come straight from the granted port; idle bus is all zeros.
  always_comb begin
    out_pwrite = 1'b0;
    out_paddr  = '0;
    out_pprot  = '0;
    out_pwdata = '0;
    out_pstrb  = '0;
    if (psel_q) begin
      if (gnt == PORT1) begin
        out_pwrite = in1_pwrite;
        out_paddr  = in1_paddr;
        out_pprot  = in1_pprot;
        out_pwdata = in1_pwdata;
        out_pstrb  = in1_pwrite ? in1_pstrb : '0;
      end else begin
        out_pwrite = in0_pwrite;
        out_paddr  = in0_paddr;
        out_pprot  = in0_pprot;
        out_pwdata = in0_pwdata;
        out_pstrb  = in0_pwrite ? in0_pstrb : '0;
      end
    end
  end

  // A requester that abandoned its access phase gets nothing back.
  assign live0 = (done || expire) && (gnt == PORT0) && in0_psel && in0_penable;
  assign live1 = (done || expire) && (gnt == PORT1) && in1_psel && in1_penable;

  always_comb begin
    in0_pready  = live0;
    in0_prdata  = '0;
    in0_pslverr = 1'b0;
    in1_pready  = live1;
    in1_prdata  = '0;
    in1_pslverr = 1'b0;
    if (live0) begin
      in0_prdata  = done ? out_prdata : '0;
      in0_pslverr = done ? out_pslverr : 1'b1;
    end
    if (live1) begin
      in1_prdata  = done ? out_prdata : '0;
      in1_pslverr = done ? out_pslverr : 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_apb_arbiter.sv
// Self-checking bench for sdram_apb_arbiter: directed scenarios plus randomized contention
// traffic checked against a transaction-level round-robin model.
module tb_sdram_apb_arbiter;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in0_psel, in0_penable, in0_pwrite, in0_pready, in0_pslverr;
  logic [31:0] in0_paddr, in0_pwdata, in0_prdata;
  logic [2:0]  in0_pprot;
  logic [3:0]  in0_pstrb;
  logic        in1_psel, in1_penable, in1_pwrite, in1_pready, in1_pslverr;
  logic [31:0] in1_paddr, in1_pwdata, in1_prdata;
  logic [2:0]  in1_pprot;
  logic [3:0]  in1_pstrb;
  logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
  logic [31:0] out_paddr, out_pwdata, out_prdata;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;

  int checks = 0;
  int fails  = 0;

  wire [141:0] all_out = {out_psel, out_penable, out_pwrite, out_paddr, out_pprot, out_pwdata,
                          out_pstrb, in0_pready, in0_prdata, in0_pslverr,
                          in1_pready, in1_prdata, in1_pslverr};

  always #5 clock = ~clock;

  sdram_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .in0_psel(in0_psel), .in0_penable(in0_penable), .in0_pwrite(in0_pwrite),
    .in0_paddr(in0_paddr), .in0_pprot(in0_pprot), .in0_pwdata(in0_pwdata),
    .in0_pstrb(in0_pstrb), .in0_pready(in0_pready), .in0_prdata(in0_prdata),
    .in0_pslverr(in0_pslverr),
    .in1_psel(in1_psel), .in1_penable(in1_penable), .in1_pwrite(in1_pwrite),
    .in1_paddr(in1_paddr), .in1_pprot(in1_pprot), .in1_pwdata(in1_pwdata),
    .in1_pstrb(in1_pstrb), .in1_pready(in1_pready), .in1_prdata(in1_prdata),
    .in1_pslverr(in1_pslverr),
    .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite),
    .out_paddr(out_paddr), .out_pprot(out_pprot), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_port(input int m, input logic psel, input logic pen, input txn_t t);
    if (m == 0) begin
      in0_psel = psel; in0_penable = pen; in0_pwrite = t.write; in0_paddr = t.addr;
      in0_pprot = t.prot; in0_pwdata = t.wdata; in0_pstrb = t.strb;
    end else begin
      in1_psel = psel; in1_penable = pen; in1_pwrite = t.write; in1_paddr = t.addr;
      in1_pprot = t.prot; in1_pwdata = t.wdata; in1_pstrb = t.strb;
    end
  endtask

  task automatic idle();
    drive_port(0, 1'b0, 1'b0, '0);
    drive_port(1, 1'b0, 1'b0, '0);
    out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.write = 1'($urandom_range(0, 1));
    t.addr  = $urandom;
    t.prot  = 3'($urandom_range(0, 7));
    t.wdata = $urandom;
    t.strb  = 4'($urandom_range(0, 15));
    return t;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    drive_port(0, 1'b1, 1'b1, '1);
    drive_port(1, 1'b1, 1'b1, '1);
    out_pready = 1'b1; out_prdata = '1; out_pslverr = 1'b1;
    @(negedge clock);
    checks++;
    if (all_out !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    idle();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    txn_t t;
    t.write = 1'b0; t.addr = 32'h8000_0000; t.prot = 3'b010; t.wdata = 32'h1234_5678; t.strb = 4'hF;
    do_reset();
    tick(); drive_port(0, 1'b1, 1'b0, t);
    @(negedge clock);
    checks++;
    if (out_psel !== 1'b0) begin
      fails++; $display("FAIL single_idle: got psel %b expected 0", out_psel);
    end
    tick(); drive_port(0, 1'b1, 1'b1, t);
    @(negedge clock);
    checks++;
    if ({out_psel, out_penable, out_paddr, out_pprot, out_pwrite, out_pstrb} !==
        {1'b1, 1'b0, 32'h8000_0000, 3'b010, 1'b0, 4'h0}) begin
      fails++; $display("FAIL single_setup: got %b %b %h %b %b %h", out_psel, out_penable,
                        out_paddr, out_pprot, out_pwrite, out_pstrb);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      out_pready = (i == 5);
      out_prdata = (i == 5) ? 32'hDEAD_BEEF : 32'h5555_AAAA;
      @(negedge clock);
      checks++;
      if ({out_penable, in0_pready} !== {1'b1, 1'(i == 5)}) begin
        fails++; $display("FAIL single_access%0d: got penable %b pready %b", i, out_penable, in0_pready);
      end
      if (i == 5) begin
        checks++;
        if ({in0_prdata, in0_pslverr} !== {32'hDEAD_BEEF, 1'b0}) begin
          fails++; $display("FAIL single_rdata: got %h/%b expected deadbeef/0", in0_prdata, in0_pslverr);
        end
        checks++;
        if ({in1_pready, in1_prdata, in1_pslverr} !== '0) begin
          fails++; $display("FAIL single_other: got %b %h %b expected 0", in1_pready, in1_prdata, in1_pslverr);
        end
      end
    end
    tick(); idle();
    @(negedge clock);
    checks++;
    if ({out_psel, in0_pready} !== 2'b00) begin
      fails++; $display("FAIL single_back_idle: got psel %b pready %b expected 0 0", out_psel, in0_pready);
    end
  endtask

  task automatic test_strobe();
    txn_t t;
    logic [31:0] d;
    for (int w = 0; w < 2; w++) begin
      t = rand_txn();
      t.write = 1'(w);
      t.strb  = (w == 1) ? 4'b0101 : 4'hF;
      tick(); drive_port(1, 1'b1, 1'b0, t);
      tick(); drive_port(1, 1'b1, 1'b1, t);
      @(negedge clock);
      checks++;
      if ({out_psel, out_penable, out_pwrite, out_pstrb, out_paddr, out_pwdata} !==
          {1'b1, 1'b0, 1'(w), (w == 1) ? 4'b0101 : 4'h0, t.addr, t.wdata}) begin
        fails++; $display("FAIL strobe_w%0d: got strb %b write %b addr %h expected strb %b addr %h",
                          w, out_pstrb, out_pwrite, out_paddr, (w == 1) ? 4'b0101 : 4'h0, t.addr);
      end
      tick(); d = $urandom; out_pready = 1'b1; out_prdata = d;
      @(negedge clock);
      checks++;
      if ({in1_pready, in1_prdata, in0_pready} !== {1'b1, d, 1'b0}) begin
        fails++; $display("FAIL strobe_resp%0d: got %b %h %b expected 1 %h 0", w, in1_pready, in1_prdata, in0_pready, d);
      end
      tick(); idle();
    end
  endtask

  task automatic test_slverr();
    txn_t a, b;
    logic [31:0] d, e;
    a = rand_txn(); b = rand_txn(); d = $urandom; e = $urandom;
    tick(); drive_port(1, 1'b1, 1'b0, a);
    tick(); drive_port(1, 1'b1, 1'b1, a); drive_port(0, 1'b1, 1'b0, b);
    tick(); drive_port(0, 1'b1, 1'b1, b);
    out_pready = 1'b1; out_pslverr = 1'b1; out_prdata = d;
    @(negedge clock);
    checks++;
    if ({in1_pready, in1_pslverr, in1_prdata} !== {1'b1, 1'b1, d}) begin
      fails++; $display("FAIL slverr_granted: got %b %b %h expected 1 1 %h", in1_pready, in1_pslverr, in1_prdata, d);
    end
    checks++;
    if ({in0_pready, in0_pslverr, in0_prdata} !== '0) begin
      fails++; $display("FAIL slverr_other: got %b %b %h expected 0", in0_pready, in0_pslverr, in0_prdata);
    end
    tick(); drive_port(1, 1'b0, 1'b0, '0); out_pready = 1'b0; out_pslverr = 1'b0;
    tick();
    @(negedge clock);
    checks++;
    if ({out_psel, out_penable, out_paddr} !== {1'b1, 1'b0, b.addr}) begin
      fails++; $display("FAIL slverr_next_setup: got %b %b %h expected 1 0 %h", out_psel, out_penable, out_paddr, b.addr);
    end
    tick(); out_pready = 1'b1; out_prdata = e;
    @(negedge clock);
    checks++;
    if ({in0_pready, in0_pslverr, in0_prdata, in1_pready} !== {1'b1, 1'b0, e, 1'b0}) begin
      fails++; $display("FAIL slverr_port0: got %b %b %h %b expected 1 0 %h 0", in0_pready, in0_pslverr, in0_prdata, in1_pready, e);
    end
    tick(); idle();
  endtask

  task automatic test_timeout();
    txn_t a, b;
    logic [31:0] d;
    a = rand_txn(); b = rand_txn(); d = $urandom;
    tick(); drive_port(0, 1'b1, 1'b0, a);
    tick(); drive_port(0, 1'b1, 1'b1, a); drive_port(1, 1'b1, 1'b0, b);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) drive_port(1, 1'b1, 1'b1, b);
      out_prdata = $urandom | 32'h1;
      @(negedge clock);
      checks++;
      if ({in0_pready, in1_pready} !== {1'(i == 16), 1'b0}) begin
        fails++; $display("FAIL timeout_cycle%0d: got pready0 %b pready1 %b", i, in0_pready, in1_pready);
      end
      if (i == 16) begin
        checks++;
        if ({in0_pslverr, in0_prdata} !== {1'b1, 32'h0}) begin
          fails++; $display("FAIL timeout_resp: got %b %h expected 1 0", in0_pslverr, in0_prdata);
        end
      end
    end
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (j == 1) drive_port(0, 1'b0, 1'b0, '0);
      @(negedge clock);
      checks++;
      if ({out_psel, out_penable, in1_pready} !== 3'b000) begin
        fails++; $display("FAIL drain_hold%0d: got %b %b %b expected 0 0 0", j, out_psel, out_penable, in1_pready);
      end
    end
    tick(); out_pready = 1'b1; out_prdata = $urandom;
    @(negedge clock);
    checks++;
    if ({out_psel, in0_pready, in1_pready} !== 3'b000) begin
      fails++; $display("FAIL drain_discard: got %b %b %b expected 0 0 0", out_psel, in0_pready, in1_pready);
    end
    tick(); out_pready = 1'b0;
    @(negedge clock);
    checks++;
    if (out_psel !== 1'b0) begin
      fails++; $display("FAIL drain_idle: got psel %b expected 0", out_psel);
    end
    tick();
    @(negedge clock);
    checks++;
    if ({out_psel, out_penable, out_paddr} !== {1'b1, 1'b0, b.addr}) begin
      fails++; $display("FAIL drain_then_grant: got %b %b %h expected 1 0 %h", out_psel, out_penable, out_paddr, b.addr);
    end
    tick(); out_pready = 1'b1; out_prdata = d;
    @(negedge clock);
    checks++;
    if ({in1_pready, in1_prdata, in1_pslverr} !== {1'b1, d, 1'b0}) begin
      fails++; $display("FAIL drain_port1_resp: got %b %h %b expected 1 %h 0", in1_pready, in1_prdata, in1_pslverr, d);
    end
    tick(); idle();
  endtask

  task automatic test_reset_mid();
    txn_t a, a2, b;
    logic [31:0] d;
    a = rand_txn(); a2 = rand_txn(); b = rand_txn(); d = $urandom;
    tick(); drive_port(0, 1'b1, 1'b0, a);
    tick(); drive_port(0, 1'b1, 1'b1, a);
    tick();
    @(negedge clock);
    checks++;
    if ({out_psel, out_penable} !== 2'b11) begin
      fails++; $display("FAIL resetmid_access: got %b %b expected 1 1", out_psel, out_penable);
    end
    tick(); out_pready = 1'b1; out_prdata = $urandom; drive_port(1, 1'b1, 1'b0, b);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (all_out !== '0) begin
      fails++; $display("FAIL resetmid_outputs: got %h expected 0", all_out);
    end
    tick(); out_pready = 1'b0; drive_port(0, 1'b1, 1'b0, a2);
    tick(); reset = 1'b1;
    tick(); drive_port(0, 1'b1, 1'b1, a2); drive_port(1, 1'b1, 1'b1, b);
    @(negedge clock);
    checks++;
    if ({out_psel, out_penable, out_paddr} !== {1'b1, 1'b0, a2.addr}) begin
      fails++; $display("FAIL resetmid_tie: got %b %b %h expected 1 0 %h", out_psel, out_penable, out_paddr, a2.addr);
    end
    tick(); out_pready = 1'b1; out_prdata = d;
    @(negedge clock);
    checks++;
    if ({in0_pready, in0_prdata, in1_pready} !== {1'b1, d, 1'b0}) begin
      fails++; $display("FAIL resetmid_resp: got %b %h %b expected 1 %h 0", in0_pready, in0_prdata, in1_pready, d);
    end
    tick(); idle();
    tick();
  endtask

  // Both requesters keep a queue of n transfers and re-request immediately, so the model
  // expects strict alternation starting at port 0 and a single idle bubble between transfers.
  task automatic test_traffic(input int n, input int max_dly, input bit rand_err);
    txn_t        q0[$], q1[$];
    txn_t        head;
    int          phase[2];
    int          done_cnt, cyc, last_done, exp_port, slv_wait;
    bit          slv_act, slv_err;
    logic [31:0] slv_rdata;
    logic [1:0]  rdy, exp_rdy;
    done_cnt = 0; cyc = 0; last_done = 0; slv_wait = 0;
    slv_act = 1'b0; slv_err = 1'b0; slv_rdata = '0;
    phase[0] = 0; phase[1] = 0;
    do_reset();
    for (int i = 0; i < n; i++) begin
      q0.push_back(rand_txn());
      q1.push_back(rand_txn());
    end
    while (done_cnt < 2 * n && cyc < 2000) begin
      tick();
      cyc++;
      for (int m = 0; m < 2; m++) begin
        int sz;
        sz = (m == 0) ? q0.size() : q1.size();
        if (phase[m] == 0 && sz > 0) phase[m] = 1;
        else if (phase[m] == 1) phase[m] = 2;
        head = '0;
        if (sz > 0) head = (m == 0) ? q0[0] : q1[0];
        drive_port(m, phase[m] != 0, phase[m] == 2, head);
      end
      out_pready  = slv_act && (slv_wait == 0);
      out_prdata  = out_pready ? slv_rdata : $urandom;
      out_pslverr = out_pready ? slv_err : 1'b0;
      @(negedge clock);
      exp_port = done_cnt % 2;
      if (exp_port == 0) head = q0[0];
      else head = q1[0];
      rdy = {in1_pready, in0_pready};
      exp_rdy = 2'b00;
      if (out_psel && !out_penable) begin
        checks++;
        if ({out_pwrite, out_paddr, out_pprot, out_pwdata, out_pstrb} !==
            {head.write, head.addr, head.prot, head.wdata, head.write ? head.strb : 4'h0}) begin
          fails++; $display("FAIL traffic_req%0d: got addr %h strb %h expected port %0d addr %h strb %h",
                            done_cnt, out_paddr, out_pstrb, exp_port, head.addr, head.write ? head.strb : 4'h0);
        end
        checks++;
        if (cyc - last_done != 2) begin
          fails++; $display("FAIL traffic_gap%0d: got %0d cycles expected 2", done_cnt, cyc - last_done);
        end
        slv_act   = 1'b1;
        slv_wait  = $urandom_range(0, max_dly);
        slv_rdata = $urandom;
        slv_err   = rand_err ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (out_psel && out_penable && out_pready) begin
        exp_rdy = 2'b01 << exp_port;
        checks++;
        if (exp_port == 0) begin
          if ({in0_pslverr, in0_prdata, in1_pslverr, in1_prdata} !== {slv_err, slv_rdata, 1'b0, 32'h0}) begin
            fails++; $display("FAIL traffic_resp%0d: got p0 %b %h p1 %b %h expected p0 %b %h",
                              done_cnt, in0_pslverr, in0_prdata, in1_pslverr, in1_prdata, slv_err, slv_rdata);
          end
          void'(q0.pop_front());
        end else begin
          if ({in1_pslverr, in1_prdata, in0_pslverr, in0_prdata} !== {slv_err, slv_rdata, 1'b0, 32'h0}) begin
            fails++; $display("FAIL traffic_resp%0d: got p1 %b %h p0 %b %h expected p1 %b %h",
                              done_cnt, in1_pslverr, in1_prdata, in0_pslverr, in0_prdata, slv_err, slv_rdata);
          end
          void'(q1.pop_front());
        end
        phase[exp_port] = 0;
        slv_act = 1'b0;
        done_cnt++;
        last_done = cyc;
      end else if (out_psel) begin
        slv_wait--;
      end else begin
        checks++;
        if ({out_penable, out_pwrite, out_paddr, out_pprot, out_pwdata, out_pstrb} !== '0) begin
          fails++; $display("FAIL traffic_idle_bus: got addr %h wdata %h strb %h expected 0", out_paddr, out_pwdata, out_pstrb);
        end
      end
      checks++;
      if (rdy !== exp_rdy) begin
        fails++; $display("FAIL traffic_pready: got %b expected %b at cycle %0d", rdy, exp_rdy, cyc);
      end
    end
    checks++;
    if (done_cnt != 2 * n) begin
      fails++; $display("FAIL traffic_complete: got %0d transfers expected %0d", done_cnt, 2 * n);
    end
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_single_read();
    test_strobe();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_traffic(3, 0, 1'b0);
    test_traffic(10, 6, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdram_apb_arbiter.md
# sdram_apb_arbiter

Two-requester APB arbiter placed in front of the APB SDRAM controller wrapper, letting two masters (e.g. instruction fetch and LSU/DMA) share the single SDRAM APB port. Round-robin on contention, one transfer in flight, a per-transfer watchdog, and a drain state that absorbs late completions after a timeout. Purely a sequencer: data/address are muxed from the granted requester, never buffered.

## Interface
Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT, 4096, cycles in ACCESS before an error response is forced; 0 disables the watchdog

Ports (N = 0,1; inN_* face the requesters, out_* face the SDRAM controller):
- clock  input  1  sole clock
- reset  input  1  asynchronous, active-low reset
- inN_psel / out_psel  in / out  1  APB select
- inN_penable / out_penable  in / out  1  APB enable
- inN_pwrite / out_pwrite  in / out  1  1 = write
- inN_paddr / out_paddr  in / out  ADDR_W  byte address
- inN_pprot / out_pprot  in / out  3  protection, passed through
- inN_pwdata / out_pwdata  in / out  DATA_W  write data
- inN_pstrb / out_pstrb  in / out  DATA_W/8  byte strobes
- inN_pready / out_pready  out / in  1  completion
- inN_prdata / out_prdata  out / in  DATA_W  read data
- inN_pslverr / out_pslverr  out / in  1  error

## Operation
- States: IDLE, SETUP, ACCESS, DRAIN. Registers: state, gnt (1 bit), last (1 bit), wdog counter.
- IDLE: if no inN_psel, stay. If exactly one asserted, gnt <= that port. If both, gnt <= ~last. Go SETUP.
- SETUP: out_psel=1, out_penable=0, out_* request fields = granted port's inputs. Unconditionally -> ACCESS.
- ACCESS: out_psel=1, out_penable=1. When out_pready=1: inGNT_pready=1, inGNT_prdata=out_prdata, inGNT_pslverr=out_pslverr in the same cycle (combinational); last <= gnt; -> IDLE.
- Watchdog: cleared on entry to ACCESS, +1 per ACCESS cycle. If TIMEOUT≠0 and count reaches TIMEOUT-1 with out_pready=0: inGNT_pready=1, pslverr=1, prdata=0; last <= gnt; -> DRAIN.
- DRAIN: out_psel=out_penable=0; wait for out_pready=1, discard response; -> IDLE. No new grant while in DRAIN.
- out_pstrb forced to 0 when out_pwrite=0.
- Non-granted port: pready=0, pslverr=0, prdata=0 always; its request simply waits.
- Granted requester dropping psel before completion (APB violation): transfer continues, response discarded, no error.
- out_* request fields when out_psel=0: all zero.

## Timing
- Reset (asserted low, async): state=IDLE, gnt=0, last=1 (port 0 wins first tie), wdog=0; all outputs 0.
- Reset mid-ACCESS/DRAIN: immediate return to IDLE; in-flight response is lost; downstream controller is reset by the same system reset.
- Minimum latency: requester SETUP at cycle t -> out SETUP at t+1 -> out ACCESS at t+2 -> requester pready at the cycle of out_pready (≥ t+2).
- Back-to-back: completion cycle -> IDLE (1 cycle) -> next SETUP; 1 bubble between transfers.
- Simultaneous requests in IDLE with last=0 -> port 1 granted, and vice versa; strict alternation under continuous contention.
- out_pready in the same cycle the watchdog expires: normal completion wins, no DRAIN.
- out_pready in SETUP or IDLE: ignored.

## Structure
- Package sdram_arb_pkg: state_t enum {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DRAIN}, port index constants PORT0/PORT1.
- One sub-module: sdram_arb_rr (round-robin picker: req[1:0], last -> gnt, valid), combinational.
- Request mux, response demux and watchdog inline in the top.

## Test plan
- Port 0 read 0x8000_0000, slave returns 0xDEAD_BEEF after 5 ACCESS cycles -> in0_pready 1 cycle with 0xDEAD_BEEF; in1 outputs stay 0; out SETUP at t+1.
- Both psel in same cycle after reset -> port 0 served first, then port 1; continuous contention for 6 transfers -> grants 0,1,0,1,0,1.
- Port 1 read with pwrite=0, pstrb=4'hF -> out_pstrb=4'h0; write pstrb=4'b0101 -> passes 4'b0101.
- TIMEOUT=16, slave silent -> in0_pready+pslverr at ACCESS cycle 16, prdata=0; state DRAIN; pending port 1 not granted until slave pready, then granted.
- Reset low during ACCESS -> all outputs 0 same cycle; after release, port 0 wins tie.
- Slave pslverr=1 on completion -> forwarded to granted requester only.
